// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory loader: state encoding, byte width,
// header limit and the B0 high-bit mask helper.
package loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned HDR_MAX = 32;

  localparam logic [STATE_W-1:0] IDLE = 3'd0;
  localparam logic [STATE_W-1:0] HDR  = 3'd1;
  localparam logic [STATE_W-1:0] B0   = 3'd2;
  localparam logic [STATE_W-1:0] B1   = 3'd3;
  localparam logic [STATE_W-1:0] B2   = 3'd4;
  localparam logic [STATE_W-1:0] WR   = 3'd5;
  localparam logic [STATE_W-1:0] DONE = 3'd6;
  localparam logic [STATE_W-1:0] ERR  = 3'd7;

  // Bits of the first word byte that lie above word[CODE_W-1:16].
  function automatic logic [BYTE_W-1:0] b0_hi_mask(input int unsigned code_w);
    return BYTE_W'({BYTE_W{1'b1}} << (code_w - 16));
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-RAM write port and status for the program loader.
interface program_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned CODE_W = 23,
  parameter int unsigned ADDR_W = 5
) ();

  logic              start;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [CODE_W-1:0] mem_wdata;
  logic              proc_hold;
  logic              done;
  logic              error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, proc_hold, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, proc_hold, done, error
  );

endinterface

// File: rtl/word_assembler.sv
// Byte shift register building a CODE_W code word, plus the B0 high-bit violation flag.
module word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned CODE_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [CODE_W-1:0] o_word_next,
  output logic              o_b0_viol
);

  localparam logic [BYTE_W-1:0] HI_MASK = b0_hi_mask(CODE_W);

  logic [CODE_W-1:0] r_sr;

  // Word as it will be once i_byte is shifted in; bits above CODE_W fall off.
  assign o_word_next = CODE_W'({r_sr, i_byte});
  assign o_b0_viol   = |(i_byte & HI_MASK);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= o_word_next;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a header-prefixed byte stream into the instruction RAM while holding the
// processor stalled; reports done or error.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned CODE_W = 23,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = HDR_MAX
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic [CNT_W-1:0]   r_n;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   w_idx_inc;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [CODE_W-1:0]  r_mem_wdata;
  logic [CODE_W-1:0]  w_word_next;
  logic               w_byte_st;
  logic               w_xfer;
  logic               w_hdr_bad;
  logic               w_b0_viol;
  logic               w_start_ok;
  logic               w_asm_load;
  logic               w_in_ready;
  logic               w_mem_we;
  logic               w_proc_hold;
  logic               w_done;
  logic               w_error;

  assign w_byte_st  = (r_state == HDR) || (r_state == B0) ||
                      (r_state == B1)  || (r_state == B2);
  assign w_xfer     = w_byte_st && bus.in_valid;
  assign w_hdr_bad  = (bus.in_data == '0) || (32'(bus.in_data) > DEPTH);
  assign w_start_ok = bus.start &&
                      ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_idx_inc  = CNT_W'(r_idx + CNT_W'(1));
  assign w_asm_load = w_xfer && (r_state != HDR);

  word_assembler #(.CODE_W(CODE_W)) u_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (r_state == HDR),
    .i_load      (w_asm_load),
    .i_byte      (bus.in_data),
    .o_word_next (w_word_next),
    .o_b0_viol   (w_b0_viol)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (w_start_ok)   w_state_next = HDR;
      HDR:             if (bus.in_valid) w_state_next = w_hdr_bad ? ERR : B0;
      B0:              if (bus.in_valid) w_state_next = w_b0_viol ? ERR : B1;
      B1:              if (bus.in_valid) w_state_next = B2;
      B2:              if (bus.in_valid) w_state_next = WR;
      WR:              w_state_next = (w_idx_inc == r_n) ? DONE : B0;
      default:         w_state_next = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    w_in_ready  = 1'b0;
    w_mem_we    = 1'b0;
    w_proc_hold = 1'b0;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      HDR, B0, B1, B2: begin
        w_in_ready  = 1'b1;
        w_proc_hold = 1'b1;
      end
      WR: begin
        w_mem_we    = 1'b1;
        w_proc_hold = 1'b1;
      end
      DONE:    w_done  = 1'b1;
      ERR:     w_error = 1'b1;
      default: ;
    endcase
  end

  // Word count, index and write-port registers; address/data are captured with the
  // last byte so they stay stable after the write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n         <= '0;
      r_idx       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if ((r_state == HDR) && w_xfer && !w_hdr_bad) begin
        r_n   <= CNT_W'(bus.in_data);
        r_idx <= '0;
      end
      if ((r_state == B2) && w_xfer) begin
        r_mem_addr  <= r_idx[ADDR_W-1:0];
        r_mem_wdata <= w_word_next;
      end
      if (r_state == WR) begin
        r_idx <= w_idx_inc;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.proc_hold = w_proc_hold;
  assign bus.done      = w_done;
  assign bus.error     = w_error;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: takes a byte stream, assembles 23-bit code words, and writes them into the instruction RAM at 5-bit addresses starting from 0.
- The new_fsm/address path is the reader of that memory. This block fills the memory before the processor runs.
- Holds the processor stalled (proc_hold) for the whole load and reports done or error.

Parameters:
- CODE_W, 23, instruction word width; must be 17..24.
- ADDR_W, 5, memory address width.
- DEPTH, 32, maximum words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  one-cycle write strobe to the instruction RAM.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  CODE_W  write data.
- proc_hold  output  1  stall request to the processor FSM.
- done  output  1  load completed; sticky until start or reset.
- error  output  1  load aborted; sticky until start or reset.

Behaviour:
- Reset, and state on the cycle after reset: IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, proc_hold=0, done=0, error=0.
  - Internal counters and shift register clear.
  - Reset mid-load discards any partial word. RAM words already written are left as they are.
- A byte transfers on a rising clk edge only when in_valid && in_ready. in_data is ignored otherwise.
- State machine (registered state; outputs decoded from state):
  - IDLE: start → HDR. proc_hold goes 1 on entry to HDR and stays 1 until DONE or ERR.
  - HDR (in_ready=1): the first byte is N, the word count.
    - N=0 or N>DEPTH → ERR.
    - Otherwise latch N, clear word index → B0.
  - B0 (in_ready=1): byte bits [CODE_W-17:0] go to word[CODE_W-1:16].
    - Any set bit above that field → ERR.
    - Otherwise → B1.
  - B1 (in_ready=1): byte → word[15:8] → B2.
  - B2 (in_ready=1): byte → word[7:0] → WR.
  - WR (in_ready=0): mem_we=1 for exactly one cycle, mem_addr=word index, mem_wdata=assembled word.
    - Word index increments.
    - If index+1 == N → DONE; else → B0.
  - DONE: done=1, proc_hold=0, in_ready=0. start → HDR and clears done.
  - ERR: error=1, proc_hold=0, in_ready=0, no further writes. start → HDR and clears error.
- Latency: the mem_we cycle directly follows the edge that accepts the third byte of a word. A full load takes at least 1+4N cycles after start.
- Stalls: in_valid low in any byte state holds the state and the shift register. There is no timeout.
- start while in HDR/B0/B1/B2/WR is ignored.
- Word index width is ADDR_W+1 so that N=DEPTH terminates correctly. The last write is at address DEPTH-1, and mem_addr never wraps.
- mem_addr and mem_wdata hold their last values outside WR. Only mem_we qualifies them.
- done and error are never 1 together.

Decomposition:
- Shared package (loader_pkg):
  - State encoding localparams: IDLE, HDR, B0, B1, B2, WR, DONE, ERR (3 bits).
  - BYTE_W=8.
  - Header-limit constant.
- One sub-module, word_assembler: a byte shift register with load-enable and clear that produces the CODE_W word and the B0 high-bit violation flag.
- The FSM and counters stay in program_loader.

Test Plan:
- Reset then idle: hold reset 2 cycles → every output 0; with no start, 10 in_valid bytes produce no mem_we.
- Single word: start, then bytes 0x01,0x12,0x34,0x56 with in_valid continuous → one mem_we, addr 0, wdata 0x123456, done=1 on the next cycle, proc_hold low again.
- Full depth: header 32, then 32 words with value = address → 32 mem_we pulses at addresses 0..31, no wrap, done=1.
- Stalls: header 2 with in_valid toggling 1-0-0-1 → words are written correctly with no extra or duplicated mem_we; in_ready=0 during WR.
- Errors, each giving error=1, no mem_we, proc_hold=0:
  - header 0;
  - header 33;
  - first word byte 0x80.
  - A later start with a valid stream clears error and loads normally.
- Reset mid-load: header 3, one word written, then reset after the B1 byte → IDLE with all outputs 0; RAM word 0 keeps its value; a new load from start succeeds.
